// File: rtl/mem_stage_sw.sv
// MEM stage with sub-word loads/stores, sized data memory and a stall/flush-controlled MEM/WB register.
// Optional alignment-exception detection is compiled in with `define MEM_ALIGN_EXC_EN.
module mem_stage_sw #(
  parameter int DM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] PC3,
  input  logic [31:0] Result3,
  input  logic [31:0] B3,
  input  logic [31:0] Instr3,
  input  logic [4:0]  WA3,
  input  logic [31:0] WD,
  input  logic        ForwardRTM,
  output logic [31:0] RD4,
  output logic [31:0] Result4,
  output logic [4:0]  WA4,
  output logic [31:0] PC4,
  output logic [31:0] Instr4,
  output logic        AdE4
);

  localparam int AW = $clog2(DM_WORDS);

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;

  // ---------------- decode ----------------
  logic [5:0] op;
  logic       is_lw, is_lb, is_lbu, is_lh, is_lhu;
  logic       is_sw, is_sb, is_sh;
  logic       is_store;

  assign op = Instr3[31:26];

  always_comb begin
    is_lw  = 1'b0;
    is_lb  = 1'b0;
    is_lbu = 1'b0;
    is_lh  = 1'b0;
    is_lhu = 1'b0;
    is_sw  = 1'b0;
    is_sb  = 1'b0;
    is_sh  = 1'b0;
    case (op)
      OP_LW:   is_lw  = 1'b1;
      OP_LB:   is_lb  = 1'b1;
      OP_LBU:  is_lbu = 1'b1;
      OP_LH:   is_lh  = 1'b1;
      OP_LHU:  is_lhu = 1'b1;
      OP_SW:   is_sw  = 1'b1;
      OP_SB:   is_sb  = 1'b1;
      OP_SH:   is_sh  = 1'b1;
      default: ;
    endcase
  end

  assign is_store = is_sw | is_sb | is_sh;

  // ---------------- addressing ----------------
  // Upper address bits are dropped so accesses wrap modulo the memory size.
  logic [AW-1:0] widx;
  logic [1:0]    lane;
  logic [31:0]   st_dat;
  logic          misaligned;

  assign widx   = Result3[AW+1:2];
  assign lane   = Result3[1:0];
  assign st_dat = ForwardRTM ? WD : B3;

`ifdef MEM_ALIGN_EXC_EN
  assign misaligned = ((is_lw | is_sw) & (lane != 2'b00)) |
                      ((is_lh | is_lhu | is_sh) & lane[0]);
`else
  assign misaligned = 1'b0;
`endif

  // ---------------- store path ----------------
  logic [3:0]  wr_be;
  logic [31:0] wr_dat;
  logic        wr_en;

  always_comb begin
    wr_be  = 4'b0000;
    wr_dat = st_dat;
    if (is_sw) begin
      wr_be  = 4'b1111;
      wr_dat = st_dat;
    end else if (is_sh) begin
      wr_be  = lane[1] ? 4'b1100 : 4'b0011;
      wr_dat = {st_dat[15:0], st_dat[15:0]};
    end else if (is_sb) begin
      wr_be  = 4'b0001 << lane;
      wr_dat = {4{st_dat[7:0]}};
    end
  end

  assign wr_en = is_store & ~stall & ~misaligned;

  logic [31:0] dm_q [DM_WORDS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DM_WORDS; i++) begin
        dm_q[i] <= '0;
      end
    end else if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) begin
          dm_q[widx][8*b +: 8] <= wr_dat[8*b +: 8];
        end
      end
    end
  end

  // ---------------- load path ----------------
  logic [31:0] rd_word;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] ld_dat;

  assign rd_word = dm_q[widx];
  assign rd_byte = rd_word[{lane, 3'b000} +: 8];
  assign rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    ld_dat = '0;
    if (is_lw) begin
      ld_dat = rd_word;
    end else if (is_lb) begin
      ld_dat = {{24{rd_byte[7]}}, rd_byte};
    end else if (is_lbu) begin
      ld_dat = {24'b0, rd_byte};
    end else if (is_lh) begin
      ld_dat = {{16{rd_half[15]}}, rd_half};
    end else if (is_lhu) begin
      ld_dat = {16'b0, rd_half};
    end
    if (misaligned) begin
      ld_dat = '0;
    end
  end

  // ---------------- MEM/WB register ----------------
  logic [31:0] rd4_q, rd4_d;
  logic [31:0] res4_q, res4_d;
  logic [4:0]  wa4_q, wa4_d;
  logic [31:0] pc4_q, pc4_d;
  logic [31:0] ins4_q, ins4_d;
  logic        ade4_q, ade4_d;

  // Flush wins over stall so a stalled bubble is still cleared.
  always_comb begin
    rd4_d  = rd4_q;
    res4_d = res4_q;
    wa4_d  = wa4_q;
    pc4_d  = pc4_q;
    ins4_d = ins4_q;
    ade4_d = ade4_q;
    if (flush) begin
      rd4_d  = '0;
      res4_d = '0;
      wa4_d  = '0;
      pc4_d  = '0;
      ins4_d = '0;
      ade4_d = 1'b0;
    end else if (!stall) begin
      rd4_d  = ld_dat;
      res4_d = Result3;
      wa4_d  = WA3;
      pc4_d  = PC3;
      ins4_d = Instr3;
      ade4_d = misaligned;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd4_q  <= '0;
      res4_q <= '0;
      wa4_q  <= '0;
      pc4_q  <= '0;
      ins4_q <= '0;
      ade4_q <= 1'b0;
    end else begin
      rd4_q  <= rd4_d;
      res4_q <= res4_d;
      wa4_q  <= wa4_d;
      pc4_q  <= pc4_d;
      ins4_q <= ins4_d;
      ade4_q <= ade4_d;
    end
  end

  assign RD4     = rd4_q;
  assign Result4 = res4_q;
  assign WA4     = wa4_q;
  assign PC4     = pc4_q;
  assign Instr4  = ins4_q;

`ifdef MEM_ALIGN_EXC_EN
  assign AdE4 = ade4_q;
`else
  assign AdE4 = 1'b0;
  logic unused_ade;
  assign unused_ade = ade4_q;
`endif

endmodule

// File: tb/tb_mem_stage_sw.sv
// Directed bench for mem_stage_sw: byte-addressed reference model plus hand-computed literal checks.
module tb_mem_stage_sw;

  localparam int DMW = 1024;
  localparam int NBYTES = 4 * DMW;

  localparam logic [5:0] LW  = 6'b100011;
  localparam logic [5:0] LB  = 6'b100000;
  localparam logic [5:0] LBU = 6'b100100;
  localparam logic [5:0] LH  = 6'b100001;
  localparam logic [5:0] LHU = 6'b100101;
  localparam logic [5:0] SW  = 6'b101011;
  localparam logic [5:0] SB  = 6'b101000;
  localparam logic [5:0] SH  = 6'b101001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, stall, flush, fwd;
  logic [31:0] pc3, res3, b3, instr3, wd;
  logic [4:0]  wa3;
  logic [31:0] RD4, Result4, PC4, Instr4;
  logic [4:0]  WA4;
  logic        AdE4;

  mem_stage_sw #(.DM_WORDS(DMW)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .PC3(pc3), .Result3(res3), .B3(b3), .Instr3(instr3), .WA3(wa3),
    .WD(wd), .ForwardRTM(fwd),
    .RD4(RD4), .Result4(Result4), .WA4(WA4), .PC4(PC4), .Instr4(Instr4), .AdE4(AdE4)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit run = 1'b0;
  int seq = 0;

`ifdef MEM_ALIGN_EXC_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  // ---------------- reference model: flat byte memory ----------------
  logic [7:0]  mm [NBYTES];
  logic [31:0] e_rd = '0, e_res = '0, e_pc = '0, e_ins = '0;
  logic [4:0]  e_wa = '0;
  logic        e_ade = 1'b0;
  int          m_a, m_w, m_h;
  logic [5:0]  m_op;
  bit          m_mis;
  logic [31:0] m_ld, m_d;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NBYTES; i++) mm[i] = 8'h00;
      e_rd = '0; e_res = '0; e_pc = '0; e_ins = '0; e_wa = '0; e_ade = 1'b0;
    end else begin
      m_a  = int'(res3 & 32'(NBYTES - 1));
      m_w  = (m_a / 4) * 4;
      m_h  = (m_a / 2) * 2;
      m_op = instr3[31:26];
      m_mis = 1'b0;
      if (ALIGN)
        m_mis = ((m_op == LW || m_op == SW) && (m_a % 4 != 0)) ||
                ((m_op == LH || m_op == LHU || m_op == SH) && (m_a % 2 != 0));
      m_ld = '0;
      case (m_op)
        LW:  m_ld = {mm[m_w+3], mm[m_w+2], mm[m_w+1], mm[m_w]};
        LB:  m_ld = {{24{mm[m_a][7]}}, mm[m_a]};
        LBU: m_ld = {24'h0, mm[m_a]};
        LH:  m_ld = {{16{mm[m_h+1][7]}}, mm[m_h+1], mm[m_h]};
        LHU: m_ld = {16'h0, mm[m_h+1], mm[m_h]};
        default: m_ld = '0;
      endcase
      if (m_mis) m_ld = '0;
      m_d = fwd ? wd : b3;
      if (!stall && !m_mis) begin
        case (m_op)
          SW: begin
            mm[m_w] = m_d[7:0]; mm[m_w+1] = m_d[15:8];
            mm[m_w+2] = m_d[23:16]; mm[m_w+3] = m_d[31:24];
          end
          SH: begin mm[m_h] = m_d[7:0]; mm[m_h+1] = m_d[15:8]; end
          SB: mm[m_a] = m_d[7:0];
          default: ;
        endcase
      end
      if (flush) begin
        e_rd = '0; e_res = '0; e_pc = '0; e_ins = '0; e_wa = '0; e_ade = 1'b0;
      end else if (!stall) begin
        e_rd = m_ld; e_res = res3; e_pc = pc3; e_ins = instr3; e_wa = wa3; e_ade = m_mis;
      end
    end
  end

  always @(negedge clk) begin
    if (run) begin
      n_cmp++;
      if ({RD4, Result4, WA4, PC4, Instr4, AdE4} !== {e_rd, e_res, e_wa, e_pc, e_ins, e_ade}) begin
        n_bad++;
        $display("FAIL model_cycle t=%0t: RD4 %h/%h Result4 %h/%h WA4 %h/%h PC4 %h/%h Instr4 %h/%h AdE4 %b/%b (got/expected)",
                 $time, RD4, e_rd, Result4, e_res, WA4, e_wa, PC4, e_pc, Instr4, e_ins, AdE4, e_ade);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic issue(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] b,
                       input logic st = 1'b0, input logic fl = 1'b0,
                       input logic fw = 1'b0, input logic [31:0] w = 32'h0);
    seq++;
    instr3 = {op, 26'(seq)};
    pc3    = pc3 + 32'd4;
    res3   = addr;
    b3     = b;
    stall  = st;
    flush  = fl;
    fwd    = fw;
    wd     = w;
    wa3    = 5'(seq);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0; fwd = 1'b0;
    pc3 = 32'h400; res3 = '0; b3 = '0; instr3 = '0; wd = '0; wa3 = '0;
    #1 run = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rd4", RD4, 32'h0);
    chk("reset_instr4", Instr4, 32'h0);
    chk("reset_pc4", PC4, 32'h0);
    reset = 1'b0;

    issue(SW, 32'h10, 32'h12345678);
    issue(LW, 32'h10, 32'h0);
    chk("word_roundtrip", RD4, 32'h12345678);
    issue(SB, 32'h12, 32'h000000AB);
    issue(LW, 32'h10, 32'h0);
    chk("byte_merge", RD4, 32'h12AB5678);
    issue(SH, 32'h10, 32'h0000BEEF);
    issue(LW, 32'h10, 32'h0);
    chk("half_merge", RD4, 32'h12ABBEEF);

    issue(SW, 32'h20, 32'h000080F0);
    issue(LB, 32'h20, 32'h0);
    chk("lb_sext", RD4, 32'hFFFFFFF0);
    issue(LBU, 32'h20, 32'h0);
    chk("lbu_zext", RD4, 32'h000000F0);
    issue(LH, 32'h20, 32'h0);
    chk("lh_sext", RD4, 32'hFFFF80F0);
    issue(LHU, 32'h20, 32'h0);
    chk("lhu_zext", RD4, 32'h000080F0);
    issue(LBU, 32'h23, 32'h0);
    chk("lbu_lane3", RD4, 32'h00000000);

    issue(SW, 32'h1004, 32'h0, 1'b0, 1'b0, 1'b1, 32'hCAFEBABE);
    issue(LW, 32'h0004, 32'h0);
    chk("fwd_wrap", RD4, 32'hCAFEBABE);

    issue(6'h00, 32'h10, 32'h0);
    chk("nonmem_rd4", RD4, 32'h0);
    chk("nonmem_result4", Result4, 32'h10);

    issue(LW, 32'h10, 32'h0);
    issue(SW, 32'h10, 32'hDEADBEEF, 1'b1);
    chk("stall_hold_rd4", RD4, 32'h12ABBEEF);
    chk("stall_hold_op", 32'(Instr4[31:26]), 32'(LW));
    issue(LW, 32'h10, 32'h0);
    chk("stall_no_write", RD4, 32'h12ABBEEF);

    issue(LW, 32'h10, 32'h0, 1'b1, 1'b1);
    chk("flush_stall_instr4", Instr4, 32'h0);
    chk("flush_stall_rd4", RD4, 32'h0);
    chk("flush_stall_pc4", PC4, 32'h0);
    issue(SW, 32'h30, 32'h00000055, 1'b0, 1'b1);
    chk("flush_pc4", PC4, 32'h0);
    issue(LW, 32'h30, 32'h0);
    chk("flush_keeps_write", RD4, 32'h00000055);

    issue(LW, 32'h11, 32'h0);
    chk("mis_lw_rd4", RD4, ALIGN ? 32'h0 : 32'h12ABBEEF);
    chk("mis_lw_ade", 32'(AdE4), ALIGN ? 32'h1 : 32'h0);
    issue(SH, 32'h13, 32'h00001111);
    chk("mis_sh_ade", 32'(AdE4), ALIGN ? 32'h1 : 32'h0);
    issue(LW, 32'h10, 32'h0);
    chk("mis_sh_mem", RD4, ALIGN ? 32'h12ABBEEF : 32'h1111BEEF);

    // Async reset pulse mid-cycle, held across an edge carrying a store.
    #3 reset = 1'b1;
    #1;
    chk("async_rst_rd4", RD4, 32'h0);
    chk("async_rst_pc4", PC4, 32'h0);
    seq++;
    instr3 = {SW, 26'(seq)}; res3 = 32'h10; b3 = 32'h99999999; stall = 1'b0; flush = 1'b0; fwd = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    issue(LW, 32'h10, 32'h0);
    chk("rst_clears_mem", RD4, 32'h0);
    issue(LW, 32'h20, 32'h0);
    chk("rst_clears_mem2", RD4, 32'h0);

    issue(6'h00, 32'h0, 32'h0);
    @(posedge clk);
    #1 run = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_stage_sw.md
Name: mem_stage_sw

Overview:
- Parametrised successor to the word-only MEM stage of the 5-stage MIPS pipeline.
- Adds sub-word loads and stores (lb/lbu/lh/lhu/sb/sh/sw/lw) and a configurable data-memory depth.
- Adds stall/flush control of the MEM/WB register and optional address-alignment exception detection.
- Sits between EX/MEM and WB; the memory-access decode comes from Instr3 inside the block.

Parameters:
DM_WORDS, 1024, data-memory depth in 32-bit words; power of 2, minimum 4
AW, $clog2(DM_WORDS), word-index width; derived, not overridden

Ports:
clk  input  1  pipeline clock, rising edge
reset  input  1  asynchronous, active-high; clears the DM array and the MEM/WB register
stall  input  1  hold MEM/WB and suppress the DM write this cycle
flush  input  1  load a bubble (all zero) into MEM/WB
PC3  input  32  PC of the instruction in MEM
Result3  input  32  ALU result: memory byte address
B3  input  32  rt value from EX/MEM
Instr3  input  32  instruction in MEM
WA3  input  5  destination register
WD  input  32  WB-stage write data, forwarding source
ForwardRTM  input  1  1: store data = WD, 0: store data = B3
RD4  output  32  registered, extended load data
Result4  output  32  registered Result3
WA4  output  5  registered WA3
PC4  output  32  registered PC3
Instr4  output  32  registered Instr3
AdE4  output  1  registered alignment exception; 0 when the feature is absent

Behaviour:
- Opcode decode on Instr3[31:26]:
  - lw 100011, lb 100000, lbu 100100, lh 100001, lhu 100101
  - sw 101011, sb 101000, sh 101001
  - any other opcode: no memory access, RD4 loads 0.
- Addressing: word index = Result3[AW+1:2]; bits above AW+1 are ignored, so addresses wrap modulo 4*DM_WORDS. Byte lane = Result3[1:0]; halfword lane = Result3[1].
- Store data source: ForwardRTM ? WD : B3.
- Store write timing: on the rising clk edge, when a store is decoded, stall=0 and reset=0.
  - sw writes the whole word.
  - sh writes data[15:0] into lane Result3[1]; the other half is unchanged.
  - sb writes data[7:0] into byte lane Result3[1:0]; the other bytes are unchanged.
  - flush does not suppress the write.
- Load read path: combinational from the array, then extended.
  - lb/lh sign-extend; lbu/lhu zero-extend.
  - Result is captured into RD4 at the next edge, so load latency is 1 cycle (same as a word DM).
- Read/write ordering: a load at the same word in the cycle after a store returns the new data. A load and a store never coexist in the stage.
- MEM/WB register, evaluated each rising edge in this priority order:
  - reset: all outputs 0.
  - else flush: all outputs 0, regardless of stall.
  - else stall: all outputs hold.
  - else: all outputs load the stage values.
- Reset values: every output is 0, and every DM word is 0 at reset assertion.
- Reset mid-operation: a write coinciding with reset is discarded; array and register are zero until reset deasserts.
- Without the alignment feature: misaligned low bits are ignored. lw/sw use the word regardless of [1:0]; lh/lhu/sh use Result3[1] only.

Optional Feature:
MEM_ALIGN_EXC_EN
- Defined:
  - Misaligned means lw/sw with Result3[1:0]!=0, or lh/lhu/sh with Result3[0]=1.
  - A misaligned store is suppressed.
  - A misaligned load registers RD4=0.
  - AdE4 registers 1 with the instruction, following the same flush/stall/reset rules as the MEM/WB register.
- Undefined: AdE4 is constant 0 and no store is suppressed for alignment.

Test Plan:
- Word round trip: sw B3=0x12345678 @0x10, then lw @0x10 -> RD4=0x12345678 one edge after the lw is in MEM.
- Byte merge: after the word above, sb B3=0xAB @0x12, then lw @0x10 -> 0x12AB5678. Follow with sh B3=0xBEEF @0x10 -> lw gives 0x12ABBEEF.
- Extension, with word 0x000080F0 @0x20:
  - lb @0x20 -> 0xFFFFFFF0; lbu @0x20 -> 0x000000F0
  - lh @0x20 -> 0xFFFF80F0; lhu @0x20 -> 0x000080F0
- Forwarding and wrap (DM_WORDS=1024):
  - sw ForwardRTM=1, WD=0xCAFEBABE, B3=0 @0x1004 -> lw @0x0004 returns 0xCAFEBABE.
- Stall/flush:
  - sw with stall=1 -> memory unchanged, outputs held.
  - flush=1 with stall=1 -> all outputs 0.
  - Async reset pulse between clk edges -> outputs 0 immediately and a prior lw reads 0.
- Alignment (macro defined): lw @0x11 -> AdE4=1, RD4=0. sh @0x13 -> memory unchanged, AdE4=1. Without the macro, the same lw returns the word at 0x10.
